// File: rtl/sdf_delay_line.sv
// sdf_delay_line: programmable-length, multi-channel sample delay for SDF FFT
// stages. This is a circular buffer of MAX_N entries per channel. Its pointer
// wraps at the active length L, so the latency is exactly L pushes.
//
// Handshake: valid is a push strobe with no ready/back-pressure. Every cycle
// with valid=1 is accepted and advances the line by one position. In cycles
// with valid=0 all state holds. The exceptions are reset and delay_load,
// which act on the edge where they are sampled.
module sdf_delay_line #(
    parameter int BW    = 16,
    parameter int NCH   = 2,
    parameter int MAX_N = 64,
    parameter int DEF_N = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid,
    input  logic [NCH*(BW+1)-1:0]    in_data,
    input  logic [$clog2(MAX_N):0]   delay_sel,
    input  logic                     delay_load,
    output logic [NCH*(BW+1)-1:0]    out_data,
    output logic                     out_valid,
    output logic [$clog2(MAX_N):0]   delay_len
);

    localparam int CW = BW + 1;
    localparam int DW = NCH * CW;
    localparam int LW = $clog2(MAX_N) + 1;
    localparam int PW = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    // Architectural state shared by all channels
    logic [LW-1:0] len_q;
    logic [LW-1:0] fill_q;
    logic [PW-1:0] ptr_q;

    // Configuration in effect for this cycle. When delay_load is high, these
    // are the freshly loaded values. A push in the same cycle then acts as
    // push 1 of the new configuration.
    logic [LW-1:0] sel_clamped;
    logic [LW-1:0] cfg_len;
    logic [LW-1:0] cfg_fill;
    logic [PW-1:0] cfg_ptr;

    // Push datapath
    logic [LW-1:0] ptr_inc;
    logic [PW-1:0] ptr_nxt;
    logic [LW-1:0] fill_nxt;
    logic          primed_nxt;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] push_data;
    logic          wr_en;

    // Clamp the requested length into 1..MAX_N
    always_comb begin
        sel_clamped = delay_sel;
        if (delay_sel == '0) begin
            sel_clamped = LW'(1);
        end else if (delay_sel > LW'(MAX_N)) begin
            sel_clamped = LW'(MAX_N);
        end
    end

    // Select the effective configuration. A load restarts the line from empty.
    always_comb begin
        cfg_len  = len_q;
        cfg_fill = fill_q;
        cfg_ptr  = ptr_q;
        if (delay_load) begin
            cfg_len  = sel_clamped;
            cfg_fill = '0;
            cfg_ptr  = '0;
        end
    end

    // Next pointer, fill count, and output selection for a push
    always_comb begin
        ptr_inc = LW'(cfg_ptr) + LW'(1);
        ptr_nxt = '0;
        if (ptr_inc < cfg_len) begin
            ptr_nxt = PW'(ptr_inc);
        end

        fill_nxt = cfg_len;
        if (cfg_fill < cfg_len) begin
            fill_nxt = cfg_fill + LW'(1);
        end
        primed_nxt = (fill_nxt == cfg_len);

        // The slot after the write pointer holds the sample from L-1 pushes
        // ago. Together with the output register, that makes the latency L.
        // With L=1 that slot is the one being written, so bypass it instead.
        push_data = rd_data;
        if (cfg_len == LW'(1)) begin
            push_data = in_data;
        end

        wr_en = valid && !reset;
    end

    // One storage array per channel. The channels share only the addressing.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [CW-1:0] mem [0:MAX_N-1];

        // Write the incoming sample at the write pointer. The RAM is never
        // cleared: the fill count masks stale entries.
        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[cfg_ptr] <= in_data[c*CW +: CW];
            end
        end

        // Asynchronous read of the oldest live entry
        always_comb begin
            rd_data[c*CW +: CW] = mem[ptr_nxt];
        end
    end

    // Control and output registers. Reset wins over load, and load wins over
    // hold. Outputs move only on push, load, or reset edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q     <= LW'(DEF_N);
            fill_q    <= '0;
            ptr_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (valid) begin
            len_q     <= cfg_len;
            fill_q    <= fill_nxt;
            ptr_q     <= ptr_nxt;
            out_valid <= primed_nxt;
            out_data  <= primed_nxt ? push_data : '0;
        end else if (delay_load) begin
            len_q     <= cfg_len;
            fill_q    <= '0;
            ptr_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end
    end

    assign delay_len = len_q;

endmodule

// File: tb/tb_sdf_delay_line.sv
// Directed bench for sdf_delay_line with the default parameters
// (BW=16, NCH=2, MAX_N=64, DEF_N=64). Expected values are worked out by hand
// or from closed-form ramp formulas.
module tb_sdf_delay_line;

    logic        clk;
    logic        reset;
    logic        valid;
    logic [33:0] in_data;
    logic [6:0]  delay_sel;
    logic        delay_load;
    logic [33:0] out_data;
    logic        out_valid;
    logic [6:0]  delay_len;

    int errors;
    int checks;

    sdf_delay_line #(
        .BW(16), .NCH(2), .MAX_N(64), .DEF_N(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .valid(valid),
        .in_data(in_data),
        .delay_sel(delay_sel),
        .delay_load(delay_load),
        .out_data(out_data),
        .out_valid(out_valid),
        .delay_len(delay_len)
    );

    // Clock and idle inputs
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        vld;
        logic        ld;
        logic [6:0]  sel;
        logic [33:0] din;
        logic [33:0] exp_d;
        logic        exp_v;
        logic [6:0]  exp_l;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [33:0] pk(input logic [16:0] c0, input logic [16:0] c1);
        return {c1, c0};
    endfunction

    function automatic void add(input logic r, input logic v, input logic l,
                                input logic [6:0] s, input logic [33:0] d,
                                input logic [33:0] ed, input logic ev,
                                input logic [6:0] el);
        vec_t x;
        x.rst = r; x.vld = v; x.ld = l; x.sel = s; x.din = d;
        x.exp_d = ed; x.exp_v = ev; x.exp_l = el;
        vecs.push_back(x);
    endfunction

    function automatic void add_idle(input int n, input logic [33:0] ed,
                                     input logic ev, input logic [6:0] el);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, 7'd0, 34'h0, ed, ev, el);
    endfunction

    // Driver: apply one cycle of inputs, then sample 1 ns after the edge
    task automatic cyc(input logic r, input logic v, input logic l,
                       input logic [6:0] s, input logic [33:0] d);
        reset = r; valid = v; delay_load = l; delay_sel = s; in_data = d;
        @(posedge clk);
        #1;
        reset = 1'b0; valid = 1'b0; delay_load = 1'b0;
    endtask

    // Scoreboard compare
    task automatic chk(input string nm, input logic [33:0] ed, input logic ev,
                       input logic [6:0] el);
        checks++;
        if (out_data !== ed || out_valid !== ev || delay_len !== el) begin
            errors++;
            $display("FAIL %s: got data=%h valid=%b len=%0d, expected data=%h valid=%b len=%0d",
                     nm, out_data, out_valid, delay_len, ed, ev, el);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b0; valid = 1'b0; delay_load = 1'b0;
        delay_sel = '0; in_data = '0;

        // Table: load L=5, pushes separated by three idle cycles
        add(0, 0, 1, 7'd5, 34'h0, 34'h0, 0, 7'd5);
        add(0, 1, 0, 7'd0, pk(17'd10, 17'd266), 34'h0, 0, 7'd5);
        add_idle(3, 34'h0, 0, 7'd5);
        add(0, 1, 0, 7'd0, pk(17'd20, 17'd276), 34'h0, 0, 7'd5);
        add_idle(3, 34'h0, 0, 7'd5);
        add(0, 1, 0, 7'd0, pk(17'd30, 17'd286), 34'h0, 0, 7'd5);
        add_idle(3, 34'h0, 0, 7'd5);
        add(0, 1, 0, 7'd0, pk(17'd40, 17'd296), 34'h0, 0, 7'd5);
        add_idle(3, 34'h0, 0, 7'd5);
        add(0, 1, 0, 7'd0, pk(17'd50, 17'd306), pk(17'd10, 17'd266), 1, 7'd5);
        add_idle(3, pk(17'd10, 17'd266), 1, 7'd5);
        add(0, 1, 0, 7'd0, pk(17'd60, 17'd316), pk(17'd20, 17'd276), 1, 7'd5);
        add_idle(3, pk(17'd20, 17'd276), 1, 7'd5);
        // Load sel=0 together with a push: L clamps to 1, pass-through
        add(0, 1, 1, 7'd0, pk(17'h1A2B, 17'h0555), pk(17'h1A2B, 17'h0555), 1, 7'd1);
        add(0, 1, 0, 7'd0, pk(17'd77, 17'd88), pk(17'd77, 17'd88), 1, 7'd1);
        add_idle(2, pk(17'd77, 17'd88), 1, 7'd1);
        // Load L=4 together with a push: that push counts as push 1
        add(0, 1, 1, 7'd4, pk(17'd7, 17'd8), 34'h0, 0, 7'd4);
        add(0, 1, 0, 7'd0, pk(17'd9, 17'd10), 34'h0, 0, 7'd4);
        add(0, 1, 0, 7'd0, pk(17'd11, 17'd12), 34'h0, 0, 7'd4);
        add_idle(1, 34'h0, 0, 7'd4);
        add(0, 1, 0, 7'd0, pk(17'd13, 17'd14), pk(17'd7, 17'd8), 1, 7'd4);
        add(0, 1, 0, 7'd0, pk(17'd15, 17'd16), pk(17'd9, 17'd10), 1, 7'd4);

        // Reset state
        cyc(1, 0, 0, 7'd0, 34'h0);
        cyc(1, 0, 0, 7'd0, 34'h0);
        chk("reset", 34'h0, 0, 7'd64);

        // Default L=64 ramp
        for (int k = 1; k <= 100; k++) begin
            cyc(0, 1, 0, 7'd0, pk(17'(k), 17'(k + 1000)));
            if (k >= 64) chk("ramp64", pk(17'(k - 63), 17'(k - 63 + 1000)), 1, 7'd64);
            else         chk("ramp64_fill", 34'h0, 0, 7'd64);
        end

        // Table-driven vectors
        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].vld, vecs[i].ld, vecs[i].sel, vecs[i].din);
            chk($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_v, vecs[i].exp_l);
        end

        // L=8 steady state, then shrink to L=3
        cyc(0, 0, 1, 7'd8, 34'h0);
        chk("load8", 34'h0, 0, 7'd8);
        for (int k = 1; k <= 20; k++) begin
            cyc(0, 1, 0, 7'd0, pk(17'(100 + k), 17'(200 + k)));
            if (k >= 8) chk("l8", pk(17'(100 + k - 7), 17'(200 + k - 7)), 1, 7'd8);
            else        chk("l8_fill", 34'h0, 0, 7'd8);
        end
        cyc(0, 0, 1, 7'd3, 34'h0);
        chk("load3", 34'h0, 0, 7'd3);
        cyc(0, 1, 0, 7'd0, pk(17'd301, 17'd401));
        chk("l3_p1", 34'h0, 0, 7'd3);
        cyc(0, 1, 0, 7'd0, pk(17'd302, 17'd402));
        chk("l3_p2", 34'h0, 0, 7'd3);
        cyc(0, 1, 0, 7'd0, pk(17'd303, 17'd403));
        chk("l3_p3", pk(17'd301, 17'd401), 1, 7'd3);
        cyc(0, 1, 0, 7'd0, pk(17'd304, 17'd404));
        chk("l3_p4", pk(17'd302, 17'd402), 1, 7'd3);
        cyc(0, 0, 0, 7'd0, pk(17'd999, 17'd999));
        chk("l3_hold", pk(17'd302, 17'd402), 1, 7'd3);

        // Oversized request clamps to MAX_N; channels carry opposite ramps
        cyc(0, 0, 1, 7'd74, 34'h0);
        chk("load74", 34'h0, 0, 7'd64);
        for (int k = 1; k <= 70; k++) begin
            cyc(0, 1, 0, 7'd0, pk(17'(k), 17'(131071 - k)));
            if (k >= 64) chk("max_n", pk(17'(k - 63), 17'(131071 - (k - 63))), 1, 7'd64);
            else         chk("max_n_fill", 34'h0, 0, 7'd64);
        end

        // Reset mid-stream with valid and load: that input is discarded
        cyc(1, 1, 1, 7'd3, pk(17'hDEAD, 17'hBEEF));
        chk("rst_prio", 34'h0, 0, 7'd64);
        for (int k = 1; k <= 64; k++) begin
            cyc(0, 1, 0, 7'd0, pk(17'(500 + k), 17'(600 + k)));
            if (k == 64) chk("post_rst", pk(17'd501, 17'd601), 1, 7'd64);
            else         chk("post_rst_fill", 34'h0, 0, 7'd64);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdf_delay_line.md
SDF_DELAY_LINE -- requirements
Module: sdf_delay_line

Interface
REQ-001 Parameter BW, default 16: per-channel sample width is BW+1 bits.
REQ-002 Parameter NCH, default 2: number of parallel channels (e.g. real/imag) that share one delay.
REQ-003 Parameter MAX_N, default 64: maximum delay length; any integer >= 1.
REQ-004 Parameter DEF_N, default 64: delay length after reset; 1 <= DEF_N <= MAX_N.
REQ-005 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port valid, input, 1 bit: push enable; the line advances only in cycles where valid=1.
REQ-008 Port in_data, input, NCH*(BW+1) bits: channel c occupies bits [c*(BW+1)+BW : c*(BW+1)].
REQ-009 Port delay_sel, input, clog2(MAX_N)+1 bits: requested delay length, sampled only when delay_load=1.
REQ-010 Port delay_load, input, 1 bit: single-cycle pulse that applies delay_sel and logically clears the line.
REQ-011 Port out_data, output, NCH*(BW+1) bits: delayed sample, registered, same channel packing as in_data.
REQ-012 Port out_valid, output, 1 bit: registered; high once the line is primed.
REQ-013 Port delay_len, output, clog2(MAX_N)+1 bits: currently active delay length L.

Function
REQ-014 The block SHALL behave as an NCH-wide, zero-initialised shift register of active length L that advances one position per cycle with valid=1 and holds all state when valid=0.
REQ-015 After the clock edge of the k-th push since reset/load, out_data SHALL equal the in_data of push k-L+1, or all zeros if k-L+1 < 1.
REQ-016 With L=1, out_data SHALL equal the sample pushed on the most recent valid edge.
REQ-017 out_data and out_valid SHALL change only on edges where valid=1, reset=1 or delay_load=1.
REQ-018 Storage SHALL be a circular buffer of MAX_N entries per channel whose pointer wraps modulo L, not modulo MAX_N, so that latency is exactly L pushes for every L.
REQ-019 A fill counter SHALL count pushes since reset/load, saturating at L; out_valid=1 exactly when fill count = L.
REQ-020 While fill count < L, out_data SHALL be zero, regardless of stale buffer contents.
REQ-021 On delay_load, L SHALL become delay_sel, clamped: 0 -> 1 and values > MAX_N -> MAX_N.
REQ-022 On delay_load, the fill counter SHALL clear, the pointer SHALL reset, out_data SHALL become 0 and out_valid SHALL become 0.
REQ-023 If delay_load and valid are both 1 in the same cycle, the load SHALL take effect and that cycle's in_data SHALL count as push 1 of the new configuration.
REQ-024 In that simultaneous case with new L=1, out_data SHALL equal that in_data and out_valid SHALL be 1 after the edge.
REQ-025 Channels SHALL be independent data paths sharing pointer, fill count and L; there is no cross-channel arithmetic.
REQ-026 No handshake back-pressure exists; every valid=1 cycle SHALL be accepted.

Reset
REQ-027 On reset=1 at a rising edge: L=DEF_N, fill count=0, pointer=0, out_data=0, out_valid=0, delay_len=DEF_N.
REQ-028 reset SHALL take priority over delay_load and valid in the same cycle; that cycle's input SHALL be discarded.
REQ-029 Buffer RAM contents need not be cleared; REQ-020 masks them.

Verification
REQ-030 Reset, default L=64, push ramp 1,2,3,... continuously -> out_valid rises after push 64, when out_data=1; after push 100, out_data=37.
REQ-031 Load delay_sel=5, push 10,20,30,40,50,60 with valid gaps of 3 idle cycles -> out_data=0 through push 4; 10 after push 5; 20 after push 6; outputs are held during gaps.
REQ-032 Load delay_sel=0 together with valid and in_data=0x1A2B -> delay_len=1, out_valid=1, out_data=0x1A2B after the edge.
REQ-033 Run with L=8 to steady state, then load delay_sel=3 -> out_valid drops for 2 pushes, out_data=0, and no pre-load sample ever appears at the output.
REQ-034 Load delay_sel=MAX_N+10 -> delay_len=MAX_N, latency = MAX_N pushes; NCH=2 channels carry distinct ramps with no cross-talk.
REQ-035 Assert reset mid-stream together with valid=1 and delay_load=1 -> outputs=0, delay_len=DEF_N, and that input is not counted.
